tx_block_framer: RTL and testbench
==================================

Name: tx_block_framer

Overview:
- TX-side counterpart of the receive alignment path.
- Accepts 64-bit payload blocks, each with a 2-bit sync header, over a valid/ready handshake.
- Serialises each block into two 32-bit words, driving data_o, head_o and the 0..65 sequence counter consumed by gearbox_66b_64b.
- Inserts idle control blocks when upstream underflows or the lane is disabled, so the RX aligner always sees legal 01/10 headers.

Parameters:
- P_SEQ_MAX, 65: last sequence value before wrap.
- P_PAUSE_SEQ, 64: first of two pause sequence values (P_PAUSE_SEQ, P_PAUSE_SEQ+1); no block is emitted during these.
- P_IDLE_HEAD, 2'b10: header of the idle control block.
- P_IDLE_BLOCK, 64'h1E00_0000_0000_0000: payload of the idle control block.
- P_CNT_WIDTH, 16: width of the saturating idle counter.

Ports:
- clk_i  in  1  lane user clock (156.25 MHz x2).
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  1 = take blocks from FIFO; 0 = force idle blocks.
- blk_valid_i  in  1  input block valid.
- blk_ready_o  out  1  input block ready (registered).
- blk_head_i  in  2  sync header of the input block.
- blk_data_i  in  64  input block payload.
- data_o  out  32  word to gearbox_66b_64b data_i.
- head_o  out  2  header to gearbox_66b_64b head_i.
- sequence_o  out  7  sequence to gearbox_66b_64b sequence_i.
- underflow_o  out  1  one-cycle pulse: idle inserted while enable_i=1.
- idle_cnt_o  out  P_CNT_WIDTH  saturating count of underflow pulses.

Behaviour:
- Reset (async assert, sync release): all outputs 0 (data_o, head_o, sequence_o, blk_ready_o, underflow_o, idle_cnt_o). FIFO is flushed and r_seq=0.
- Reset mid-operation discards any partially sent block.
- The first edge after release drives sequence_o=0, carrying the upper half of the first block.
- r_seq counts 0..P_SEQ_MAX every cycle, unconditionally, and wraps to 0.
- At every edge, all three outputs register together: sequence_o<=r_seq, with data_o/head_o selected by r_seq. The three are therefore always cycle-aligned.
- Slot start (r_seq even and r_seq<P_PAUSE_SEQ):
  - if enable_i and FIFO non-empty: pop the head entry into the shadow register.
  - otherwise: load P_IDLE_HEAD/P_IDLE_BLOCK into the shadow register.
  - Then data_o<=shadow[63:32] and head_o<=shadow head, both taken from the same-cycle selection.
- Odd r_seq < P_PAUSE_SEQ: data_o<=shadow[31:0]; head_o holds.
- r_seq = P_PAUSE_SEQ or P_PAUSE_SEQ+1: data_o<=0, head_o holds, no pop.
- underflow_o=1 for exactly one cycle at a slot start with enable_i=1 and FIFO empty.
- idle_cnt_o increments on each underflow pulse and saturates at all-ones. It is not incremented for idles inserted because enable_i=0.
- FIFO:
  - 2 entries of 66 bits.
  - Write on blk_valid_i & blk_ready_o.
  - blk_ready_o <= (next occupancy < 2), computed from this cycle's push and pop.
  - Push and pop in the same cycle are both performed and occupancy is unchanged.
  - A write at edge E is poppable at edge E+1.
- Latency: minimum 1 cycle from acceptance to sequence_o carrying the block's upper half; maximum 4 cycles when acceptance falls just before the pause.
- Throughput: 32 blocks per 66 cycles. Upstream sees ready deassert when it outruns this rate.
- enable_i toggling takes effect only at slot start; a slot in progress completes unchanged.
- Illegal headers (00/11) from upstream are passed through unmodified. Checking them belongs upstream.

Decomposition:
- Package tx_framer_pkg holds:
  - typedef blk_t {logic [1:0] head; logic [63:0] data;}
  - the idle header/payload constants
  - the 7-bit sequence type
- One natural sub-module: sync_fifo_2 (2-deep registered-ready FIFO over blk_t), reusable on the RX side.

Test Plan:
- Reset release, blk_valid_i=0, enable_i=1 -> sequence_o follows 0,1,...,65,0. data_o alternates 32'h1E000000, 32'h00000000 with head_o=2'b10. underflow_o pulses at every even r_seq<64. idle_cnt_o reaches 32 after one sequence period.
- Continuous blocks {01, 64'h00ff00ff_00ff00ff}, valid held high -> data_o=32'h00ff00ff and head_o=01 on all non-pause cycles. data_o=0 at sequence_o 64/65. blk_ready_o drops within 2 cycles of the pause. No underflow pulses.
- Incrementing 64-bit payload, looped through gearbox_66b_64b -> gearbox_64b_66b -> rx_alignment -> lock is asserted, and the received 64-bit words increment by 1 with no gaps over 10000 blocks.
- Upstream stalls 10 cycles mid-stream -> exactly the missed slots carry idle. underflow_o pulse count equals the missed slots. The payload sequence resumes unbroken.
- enable_i deasserted at an odd r_seq -> the current block completes. The next slots are idle and idle_cnt_o does not increment. FIFO contents are preserved and emitted, in order, after re-enable.
- rst_n_i asserted asynchronously mid-slot with the FIFO full -> outputs go to 0 immediately. After release, sequence_o restarts at 0 and no pre-reset block ever appears on data_o.

Source files
------------

// File: rtl/tx_framer_pkg.sv
// Shared types and constants for the TX block framer and its 2-deep block FIFO.
package tx_framer_pkg;

    typedef logic [6:0] seq_t;

    typedef struct packed {
        logic [1:0]  head;
        logic [63:0] data;
    } blk_t;

    localparam logic [1:0]  IDLE_HEAD  = 2'b10;
    localparam logic [63:0] IDLE_BLOCK = 64'h1E00_0000_0000_0000;

    function automatic seq_t seq_next(input seq_t cur, input seq_t last);
        return (cur == last) ? 7'd0 : cur + 7'd1;
    endfunction

endpackage

// File: rtl/tx_block_framer_sync_fifo_2.sv
// Two-entry block FIFO with a registered ready; a write becomes readable on the next edge.
module sync_fifo_2
    import tx_framer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic wr_valid_i,
    output logic wr_ready_o,
    input  blk_t wr_blk_i,
    input  logic rd_en_i,
    output blk_t rd_blk_o,
    output logic empty_o
);

    blk_t       mem_r [0:1];
    logic [1:0] count_r;
    logic [1:0] count_next_s;
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic       push_s;
    logic       pop_s;

    // Handshake qualification and next occupancy from this cycle's push and pop.
    always_comb begin
        push_s       = wr_valid_i & wr_ready_o;
        pop_s        = rd_en_i & (count_r != 2'd0);
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers, occupancy and registered ready.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_r[0]   <= '0;
            mem_r[1]   <= '0;
            count_r    <= 2'd0;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            wr_ready_o <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_blk_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r    <= count_next_s;
            wr_ready_o <= (count_next_s != 2'd2);
        end
    end

    assign rd_blk_o = mem_r[rd_ptr_r];
    assign empty_o  = (count_r == 2'd0);

endmodule

// File: rtl/tx_block_framer.sv
// Serialises 66-bit blocks into 32-bit words with a free-running 0..65 gearbox sequence,
// substituting idle control blocks whenever no block can be taken at a slot start.
module tx_block_framer
    import tx_framer_pkg::*;
#(
    parameter seq_t            P_SEQ_MAX    = 7'd65,
    parameter seq_t            P_PAUSE_SEQ  = 7'd64,
    parameter logic [1:0]      P_IDLE_HEAD  = IDLE_HEAD,
    parameter logic [63:0]     P_IDLE_BLOCK = IDLE_BLOCK,
    parameter int unsigned     P_CNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [1:0]             blk_head_i,
    input  logic [63:0]            blk_data_i,
    output logic [31:0]            data_o,
    output logic [1:0]             head_o,
    output logic [6:0]             sequence_o,
    output logic                   underflow_o,
    output logic [P_CNT_WIDTH-1:0] idle_cnt_o
);

    seq_t        seq_r;
    logic [31:0] low_half_r;
    blk_t        in_blk_s;
    blk_t        fifo_blk_s;
    blk_t        sel_s;
    logic        fifo_empty_s;
    logic        slot_start_s;
    logic        take_s;
    logic        underflow_s;

    assign in_blk_s = {blk_head_i, blk_data_i};

    sync_fifo_2 u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wr_valid_i (blk_valid_i),
        .wr_ready_o (blk_ready_o),
        .wr_blk_i   (in_blk_s),
        .rd_en_i    (take_s),
        .rd_blk_o   (fifo_blk_s),
        .empty_o    (fifo_empty_s)
    );

    // Slot-start decision: pop a queued block or fall back to an idle block.
    always_comb begin
        slot_start_s = ~seq_r[0] & (seq_r < P_PAUSE_SEQ);
        take_s       = slot_start_s & enable_i & ~fifo_empty_s;
        underflow_s  = slot_start_s & enable_i & fifo_empty_s;
        if (take_s) begin
            sel_s = fifo_blk_s;
        end else begin
            sel_s = '{head: P_IDLE_HEAD, data: P_IDLE_BLOCK};
        end
    end

    // Sequence counter and the cycle-aligned word/header/sequence outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seq_r       <= 7'd0;
            low_half_r  <= 32'd0;
            sequence_o  <= 7'd0;
            data_o      <= 32'd0;
            head_o      <= 2'b00;
            underflow_o <= 1'b0;
            idle_cnt_o  <= '0;
        end else begin
            seq_r       <= seq_next(seq_r, P_SEQ_MAX);
            sequence_o  <= seq_r;
            underflow_o <= underflow_s;
            if (underflow_s && (idle_cnt_o != '1)) begin
                idle_cnt_o <= idle_cnt_o + {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            // Only the lower half needs keeping; the upper half leaves on this edge.
            if (slot_start_s) begin
                low_half_r <= sel_s.data[31:0];
                data_o     <= sel_s.data[63:32];
                head_o     <= sel_s.head;
            end else if (seq_r < P_PAUSE_SEQ) begin
                data_o <= low_half_r;
            end else begin
                data_o <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_tx_block_framer.sv
// Self-checking bench for tx_block_framer: queue-based reference model compared every cycle.
module tb_tx_block_framer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        blk_valid_i = 1'b0;
    logic        blk_ready_o;
    logic [1:0]  blk_head_i = 2'b01;
    logic [63:0] blk_data_i = 64'd0;
    logic [31:0] data_o;
    logic [1:0]  head_o;
    logic [6:0]  sequence_o;
    logic        underflow_o;
    logic [15:0] idle_cnt_o;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [65:0] q[$];
    logic [65:0] cur = 66'd0;
    int          k = 0;
    logic [6:0]  m_seq = 7'd0;
    logic [31:0] m_data = 32'd0;
    logic [1:0]  m_head = 2'b00;
    logic        m_uf = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_ready = 1'b0;
    logic        post_rst = 1'b0;

    // Source state
    logic        const_mode = 1'b0;
    logic [63:0] const_data = 64'd0;
    logic [63:0] pay = 64'd1;
    logic [1:0]  src_head = 2'b01;

    tx_block_framer dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .enable_i    (enable_i),
        .blk_valid_i (blk_valid_i),
        .blk_ready_o (blk_ready_o),
        .blk_head_i  (blk_head_i),
        .blk_data_i  (blk_data_i),
        .data_o      (data_o),
        .head_o      (head_o),
        .sequence_o  (sequence_o),
        .underflow_o (underflow_o),
        .idle_cnt_o  (idle_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 66-cycle frame, two words per block in slots 0..63, words 64/65 empty.
    initial begin
        int s;
        logic acc;
        forever begin
            @(posedge clk_i or negedge rst_n_i);
            if (!rst_n_i) begin
                q.delete();
                cur = 66'd0; k = 0;
                m_seq = 7'd0; m_data = 32'd0; m_head = 2'b00;
                m_uf = 1'b0; m_cnt = 16'd0; m_ready = 1'b0;
            end else begin
                s = k % 66;
                acc = blk_valid_i && m_ready;
                if (s < 64 && (s % 2) == 0) begin
                    if (enable_i && q.size() > 0) begin
                        cur = q.pop_front();
                        m_uf = 1'b0;
                    end else begin
                        cur = {2'b10, 64'h1E00_0000_0000_0000};
                        m_uf = enable_i;
                        if (enable_i && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end
                    m_data = cur[63:32];
                    m_head = cur[65:64];
                end else begin
                    m_uf = 1'b0;
                    m_data = (s < 64) ? cur[31:0] : 32'd0;
                end
                m_seq = 7'(s);
                if (acc) q.push_back({blk_head_i, blk_data_i});
                m_ready = (q.size() < 2);
                k++;
            end
        end
    end

    // Compare process, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                check("sequence", 66'(sequence_o), 66'(m_seq));
                check("data", 66'(data_o), 66'(m_data));
                check("head", 66'(head_o), 66'(m_head));
                check("underflow", 66'(underflow_o), 66'(m_uf));
                check("idle_cnt", 66'(idle_cnt_o), 66'(m_cnt));
                check("ready", 66'(blk_ready_o), 66'(m_ready));
                if (post_rst) begin
                    check("no_stale_word",
                          66'((data_o == 32'hDEADBEEF) || (data_o == 32'hCAFEF00D)), 66'd0);
                end
            end
        end
    end

    task automatic drive(input int n, input logic v, input logic en);
        logic acc;
        for (int i = 0; i < n; i++) begin
            enable_i    = en;
            blk_valid_i = v;
            blk_head_i  = src_head;
            blk_data_i  = const_mode ? const_data : pay;
            acc = v && blk_ready_o;
            @(posedge clk_i);
            #2;
            if (acc) pay = pay + 64'd1;
        end
    endtask

    initial begin
        // Reset values
        @(posedge clk_i); #2;
        @(posedge clk_i); #2;
        check("rst_data", 66'(data_o), 66'd0);
        check("rst_head", 66'(head_o), 66'd0);
        check("rst_seq", 66'(sequence_o), 66'd0);
        check("rst_ready", 66'(blk_ready_o), 66'd0);
        check("rst_uf", 66'(underflow_o), 66'd0);
        check("rst_cnt", 66'(idle_cnt_o), 66'd0);
        rst_n_i = 1'b1;

        // One full period of idles with enable high and no upstream data
        drive(66, 1'b0, 1'b1);
        check("idle_period_cnt", 66'(idle_cnt_o), 66'd32);
        check("idle_period_seq", 66'(sequence_o), 66'd65);
        check("idle_period_data", 66'(data_o), 66'd0);
        check("idle_period_head", 66'(head_o), 66'(2'b10));

        // Continuous constant blocks
        const_mode = 1'b1;
        const_data = 64'h00ff00ff_00ff00ff;
        src_head   = 2'b01;
        drive(200, 1'b1, 1'b1);
        check("const_seq", 66'(sequence_o), 66'd1);
        check("const_data", 66'(data_o), 66'(32'h00ff00ff));
        check("const_head", 66'(head_o), 66'(2'b01));
        check("const_uf", 66'(underflow_o), 66'd0);

        // Incrementing payload with a 10-cycle upstream stall
        const_mode = 1'b0;
        drive(100, 1'b1, 1'b1);
        drive(10, 1'b0, 1'b1);
        drive(100, 1'b1, 1'b1);

        // Disable so that the first disabled edge has an odd sequence
        while ((k % 66) != 11) drive(1, 1'b1, 1'b1);
        drive(20, 1'b1, 1'b0);
        drive(70, 1'b1, 1'b1);

        // Asynchronous reset with FIFO full of marker blocks
        const_mode = 1'b1;
        const_data = 64'hDEADBEEF_CAFEF00D;
        drive(30, 1'b1, 1'b1);
        drive(4, 1'b1, 1'b0);
        #1 rst_n_i = 1'b0;
        #1;
        check("async_rst_data", 66'(data_o), 66'd0);
        check("async_rst_head", 66'(head_o), 66'd0);
        check("async_rst_seq", 66'(sequence_o), 66'd0);
        check("async_rst_ready", 66'(blk_ready_o), 66'd0);
        check("async_rst_cnt", 66'(idle_cnt_o), 66'd0);
        blk_valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #2;
        rst_n_i  = 1'b1;
        post_rst = 1'b1;
        drive(1, 1'b0, 1'b1);
        check("restart_seq", 66'(sequence_o), 66'd0);
        check("restart_data", 66'(data_o), 66'(32'h1E000000));
        check("restart_head", 66'(head_o), 66'(2'b10));
        drive(69, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
